// File: rtl/silife_grid_wb_master_if.sv
// Wishbone classic bus between the grid row mover and a memory slave.
// Master drives cycle/strobe/address/write data; slave returns ack/read data.
interface silife_grid_wb_master_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    modport master (
        output o_wb_cyc,
        output o_wb_stb,
        output o_wb_we,
        output o_wb_addr,
        output o_wb_data,
        input  i_wb_ack,
        input  i_wb_data
    );

    modport slave (
        input  o_wb_cyc,
        input  o_wb_stb,
        input  o_wb_we,
        input  o_wb_addr,
        input  o_wb_data,
        output i_wb_ack,
        output i_wb_data
    );
endinterface

// File: rtl/silife_grid_wb_master.sv
// Moves a HEIGHT x WIDTH cell grid between a row stream and Wishbone memory,
// one row per bus cycle, with a per-row ack timeout.
module silife_grid_wb_master #(
    parameter int          WIDTH     = 8,
    parameter int          HEIGHT    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 write_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    silife_grid_wb_master_if.master wb
);
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, BUS, EMIT} state_t;

    state_t           state;
    state_t           state_nx;
    logic             mode;
    logic [RW-1:0]    row;
    logic [TW-1:0]    wait_cnt;
    logic [WIDTH-1:0] row_data;

    logic in_bus;
    logic ack_ok;
    logic timeout;
    logic last;
    logic row_done;

    assign in_bus   = (state == BUS);
    assign ack_ok   = in_bus && wb.i_wb_ack;
    // An ack in the final wait cycle wins over the timeout.
    assign timeout  = in_bus && !wb.i_wb_ack && (wait_cnt == WAIT_MAX);
    assign last     = (row == LAST_ROW);
    assign row_done = (ack_ok && mode) || ((state == EMIT) && out_ready);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = write_mode ? LOAD : BUS;
            LOAD: if (in_valid) state_nx = BUS;
            BUS: begin
                if (wb.i_wb_ack) begin
                    if (!mode)     state_nx = EMIT;
                    else if (last) state_nx = IDLE;
                    else           state_nx = LOAD;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            EMIT: if (out_ready) state_nx = last ? IDLE : BUS;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= 1'b0;
            row      <= '0;
            wait_cnt <= '0;
            row_data <= '0;
            out_data <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= row_done && last;
            error <= timeout;
            if ((state == IDLE) && start) begin
                mode <= write_mode;
                row  <= '0;
            end
            if (row_done) row <= last ? '0 : row + 1'b1;
            if ((state == LOAD) && in_valid) row_data <= in_data;
            // Every BUS visit is preceded by a non-BUS cycle, so it starts at 0.
            if (!in_bus)              wait_cnt <= '0;
            else if (!wb.i_wb_ack)    wait_cnt <= wait_cnt + 1'b1;
            if (ack_ok && !mode) out_data <= wb.i_wb_data[WIDTH-1:0];
        end
    end

    assign busy         = (state != IDLE);
    assign in_ready     = (state == LOAD);
    assign out_valid    = (state == EMIT);
    assign wb.o_wb_cyc  = in_bus;
    assign wb.o_wb_stb  = in_bus;
    assign wb.o_wb_we   = in_bus && mode;
    assign wb.o_wb_addr = in_bus ? (BASE_ADDR + (32'(row) << 2)) : 32'h0;
    assign wb.o_wb_data = (in_bus && mode) ? 32'(row_data) : 32'h0;
endmodule

// File: tb/tb_silife_grid_wb_master.sv
// Bench for silife_grid_wb_master: scoreboarded load/dump transfers,
// out stall, ack timeout, mid-transfer reset and ignored start.
module tb_silife_grid_wb_master;
    localparam int          W    = 8;
    localparam int          H    = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       write_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       busy, done, error, in_ready, out_valid;
    logic [7:0] out_data;

    silife_grid_wb_master_if wb();

    silife_grid_wb_master #(
        .WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .write_mode(write_mode),
        .busy(busy), .done(done), .error(error),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .wb(wb)
    );

    always #5 clk = ~clk;

    // Registered-ack memory slave.
    logic       no_ack = 1'b0;
    logic [7:0] mem [H];

    always @(posedge clk) begin
        if (reset) begin
            wb.i_wb_ack  <= 1'b0;
            wb.i_wb_data <= 32'h0;
        end else begin
            wb.i_wb_ack  <= wb.o_wb_stb && !wb.i_wb_ack && !no_ack;
            wb.i_wb_data <= {24'h0, mem[wb.o_wb_addr[4:2]]};
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] out_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int cyc_n = 0, ack_cnt = 0, done_cnt = 0, err_cnt = 0, stb_cnt = 0;
    int stb_rise = 0, last_comp = 0;
    logic        p_stb = 0, p_ack = 0, p_we = 0, p_ov = 0, p_or = 1;
    logic [31:0] p_addr = 0, p_data = 0;
    logic [7:0]  p_od = 0;

    always @(negedge clk) begin
        bus_t e;
        logic [7:0] eo;
        if (!reset) begin
            if (wb.o_wb_stb) stb_cnt <= stb_cnt + 1;
            if (wb.o_wb_stb && !p_stb) stb_rise <= cyc_n;
            if (p_stb && !p_ack && wb.o_wb_stb)
                check(wb.o_wb_addr == p_addr && wb.o_wb_data == p_data &&
                      wb.o_wb_we == p_we, "bus_stable", wb.o_wb_addr, p_addr);
            if (wb.o_wb_stb && wb.i_wb_ack) begin
                ack_cnt <= ack_cnt + 1;
                if (wb.o_wb_we) last_comp <= cyc_n;
                if (bus_q.size() == 0) begin
                    check(1'b0, "bus_unexpected", wb.o_wb_addr, 32'h0);
                end else begin
                    e = bus_q.pop_front();
                    check(wb.o_wb_addr == e.addr, "wb_addr", wb.o_wb_addr, e.addr);
                    check(wb.o_wb_we == e.we && wb.o_wb_data == e.data,
                          "wb_we_data", wb.o_wb_data, e.data);
                end
            end
            if (out_valid && !p_ov)
                check(cyc_n - stb_rise == 2, "dump_latency", cyc_n - stb_rise, 2);
            if (p_ov && !p_or)
                check(out_valid && out_data == p_od && !wb.o_wb_stb,
                      "out_hold", {23'h0, out_valid, out_data}, {24'h1, p_od});
            if (out_valid && out_ready) begin
                last_comp <= cyc_n;
                if (out_q.size() == 0) begin
                    check(1'b0, "out_unexpected", out_data, 32'h0);
                end else begin
                    eo = out_q.pop_front();
                    check(out_data == eo, "out_data", out_data, eo);
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                check(cyc_n == last_comp + 1, "done_timing", cyc_n - last_comp, 1);
            end
            if (error) err_cnt <= err_cnt + 1;
        end
        cyc_n  <= cyc_n + 1;
        p_stb  <= wb.o_wb_stb;
        p_ack  <= wb.i_wb_ack;
        p_we   <= wb.o_wb_we;
        p_addr <= wb.o_wb_addr;
        p_data <= wb.o_wb_data;
        p_ov   <= out_valid;
        p_or   <= out_ready;
        p_od   <= out_data;
    end

    typedef struct {
        bit mode;
        int kind;
        int stall;
        bit bstart;
        int acks;
        int dones;
    } vec_t;

    function automatic logic [7:0] pat(input int kind, input int r);
        case (kind)
            0:       return 8'(1 << r);
            1:       return (r % 2 == 1) ? 8'h55 : 8'hAA;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic push_expect(input bit mode, input int kind, output logic [7:0] d [H]);
        for (int r = 0; r < H; r++) begin
            d[r] = pat(kind, r);
            if (mode) begin
                bus_q.push_back('{addr: BASE + 32'(4 * r), we: 1'b1, data: {24'h0, d[r]}});
            end else begin
                mem[r] = d[r];
                bus_q.push_back('{addr: BASE + 32'(4 * r), we: 1'b0, data: 32'h0});
                out_q.push_back(d[r]);
            end
        end
    endtask

    task automatic run(input vec_t v);
        logic [7:0] d [H];
        int a0, d0, e0, idx, oidx, stalls, n;
        bit ihs, ohs, fin;
        push_expect(v.mode, v.kind, d);
        a0 = ack_cnt; d0 = done_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        start = 1'b1; write_mode = v.mode;
        idx = 0; oidx = 0; stalls = 0; ihs = 0; ohs = 0; fin = 0; n = 0;
        while (!fin && n < 400) begin
            @(posedge clk); #1;
            n++;
            start      = v.bstart && (n == 6);
            write_mode = (v.bstart && n == 6) ? !v.mode : v.mode;
            if (ihs) idx++;
            if (ohs) oidx++;
            in_valid = v.mode && (idx < H);
            in_data  = (idx < H) ? d[idx] : 8'h00;
            if (out_valid && oidx == 3 && stalls < v.stall) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            ihs = in_valid && in_ready;
            ohs = out_valid && out_ready;
            if (!busy) fin = 1;
        end
        if (!fin) check(1'b0, "transfer_timeout", n, 400);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(ack_cnt - a0 == v.acks, "ack_count", ack_cnt - a0, v.acks);
        check(done_cnt - d0 == v.dones, "done_count", done_cnt - d0, v.dones);
        check(err_cnt == e0, "no_error", err_cnt - e0, 0);
        check(bus_q.size() + out_q.size() == 0, "queue_drained",
              bus_q.size() + out_q.size(), 0);
    endtask

    vec_t vecs [5];

    initial begin
        int s0, d0, e0, n;
        logic [7:0] dd [H];
        vecs[0] = '{mode: 1'b0, kind: 0, stall: 0, bstart: 1'b0, acks: 8, dones: 1};
        vecs[1] = '{mode: 1'b1, kind: 1, stall: 0, bstart: 1'b0, acks: 8, dones: 1};
        vecs[2] = '{mode: 1'b0, kind: 2, stall: 5, bstart: 1'b0, acks: 8, dones: 1};
        vecs[3] = '{mode: 1'b1, kind: 2, stall: 0, bstart: 1'b1, acks: 8, dones: 1};
        vecs[4] = '{mode: 1'b0, kind: 2, stall: 0, bstart: 1'b1, acks: 8, dones: 1};
        for (int r = 0; r < H; r++) mem[r] = 8'h00;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check({busy, done, error, in_ready, out_valid, out_data,
               wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we} == 16'h0,
              "reset_ctrl", {busy, done, error, in_ready, out_valid, out_data}, 0);
        check(wb.o_wb_addr == 32'h0, "reset_addr", wb.o_wb_addr, 0);
        check(wb.o_wb_data == 32'h0, "reset_wdata", wb.o_wb_data, 0);

        for (int i = 0; i < 5; i++) run(vecs[i]);

        // No ack ever: strobe for TIMEOUT cycles, then error and back to idle.
        no_ack = 1'b1;
        s0 = stb_cnt; d0 = done_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        start = 1'b1; write_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check(1'b0, "timeout_hang", n, 100);
        repeat (2) @(posedge clk);
        #1;
        check(stb_cnt - s0 == 15, "timeout_stb_cycles", stb_cnt - s0, 15);
        check(err_cnt - e0 == 1, "timeout_error_pulse", err_cnt - e0, 1);
        check(done_cnt == d0, "timeout_no_done", done_cnt - d0, 0);
        check(!busy, "timeout_idle", busy, 0);
        no_ack = 1'b0;

        // Reset while row 2 is on the bus.
        push_expect(1'b0, 0, dd);
        d0 = done_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        start = 1'b1; write_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(wb.o_wb_stb && wb.o_wb_addr == BASE + 32'h8) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check(1'b0, "row2_not_reached", n, 100);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(!wb.o_wb_cyc && !wb.o_wb_stb && !busy, "reset_abort",
              {wb.o_wb_cyc, wb.o_wb_stb, busy}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_q.delete();
        out_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check(done_cnt == d0 && err_cnt == e0, "reset_no_pulse",
              (done_cnt - d0) + (err_cnt - e0), 0);
        run('{mode: 1'b0, kind: 1, stall: 0, bstart: 1'b1, acks: 8, dones: 1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/silife_grid_wb_master.md
SILIFE_GRID_WB_MASTER -- requirements
Module: silife_grid_wb_master

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 8, cells per row; data bits per row transfer.
- HEIGHT, 8, rows per grid; rows per burst.
- BASE_ADDR, 32'h3000_0000, Wishbone byte address of row 0.
- TIMEOUT, 15, maximum cycles to wait for i_wb_ack per row.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle request to begin a grid transfer.
- write_mode, in, 1, sampled with start: 1 = load grid, 0 = dump grid.
- busy, out, 1, transfer in progress.
- done, out, 1, one-cycle pulse when all HEIGHT rows complete.
- error, out, 1, one-cycle pulse on ack timeout.
- in_data, in, WIDTH, row data to load.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, master accepts in_data.
- out_data, out, WIDTH, dumped row data.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, consumer accepts out_data.
- o_wb_cyc, out, 1, Wishbone cycle.
- o_wb_stb, out, 1, Wishbone strobe.
- o_wb_we, out, 1, Wishbone write enable.
- o_wb_addr, out, 32, Wishbone byte address.
- o_wb_data, out, 32, Wishbone write data.
- i_wb_ack, in, 1, Wishbone acknowledge.
- i_wb_data, in, 32, Wishbone read data.
REQ-003 Clock SHALL be clk; reset SHALL be reset, synchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, BUS, EMIT; busy SHALL be 1 in every state except IDLE.
REQ-005 In IDLE, start=1 SHALL latch write_mode, clear row counter to 0, and go to LOAD if write_mode=1, else to BUS.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 In LOAD, in_ready SHALL be 1; on in_valid&in_ready, in_data SHALL be registered and state SHALL go to BUS next cycle.
REQ-008 In BUS, o_wb_cyc and o_wb_stb SHALL be 1, o_wb_we SHALL equal latched mode, o_wb_addr SHALL equal BASE_ADDR + 4*row.
REQ-009 o_wb_data SHALL be the registered row zero-extended to 32 bits in load mode; it SHALL be 0 in dump mode.
REQ-010 cyc/stb/we/addr/data SHALL stay stable in BUS until i_wb_ack is sampled 1.
REQ-011 On the edge where i_wb_ack=1 is sampled, cyc and stb SHALL deassert, so they are 0 in the following cycle.
REQ-012 On ack in dump mode, i_wb_data[WIDTH-1:0] SHALL be captured into out_data and state SHALL go to EMIT.
REQ-013 In EMIT, out_valid SHALL be 1 and out_data SHALL be held until out_valid&out_ready.
REQ-014 Row completion SHALL occur on ack (load mode) or on out handshake (dump mode).
REQ-015 On row completion with row<HEIGHT-1: row SHALL increment and state SHALL go to LOAD (load) or BUS (dump).
REQ-016 On row completion with row=HEIGHT-1: done SHALL pulse 1 for one cycle, row SHALL wrap to 0, state SHALL go to IDLE.
REQ-017 Row counter width SHALL be $clog2(HEIGHT); address arithmetic SHALL be 32-bit, with no overflow check.
REQ-018 A wait counter SHALL reset to 0 on BUS entry and increment each BUS cycle without ack.
REQ-019 If the wait counter reaches TIMEOUT without ack, cyc/stb SHALL drop, error SHALL pulse for one cycle, state SHALL go to IDLE, and done SHALL not pulse.
REQ-020 An ack arriving on the same cycle the timeout is reached SHALL take priority; no error in that case.
REQ-021 i_wb_ack SHALL be ignored outside BUS.
REQ-022 Dump-mode latency SHALL be: stb asserted cycle N; a registered responder acks in cycle N+1; out_valid=1 in cycle N+2.

Reset
REQ-023 On reset, state SHALL be IDLE and row and wait counters SHALL be 0.
REQ-024 On reset, every output SHALL be 0, including out_data, o_wb_addr and o_wb_data.
REQ-025 Reset asserted mid-transfer SHALL abort it with no done or error pulse; cyc/stb SHALL be 0 the cycle after the reset edge.

Verification
REQ-026 Dump, HEIGHT=8, registered-ack responder with rows 0x01..0x80, out_ready=1: out_data sequence 01,02,..,80; addresses 0x3000_0000..0x3000_001C; done 1 cycle after the last out handshake.
REQ-027 Load, in_data stream AA,55,..: each BUS cycle has we=1 and o_wb_data=0x000000AA/0x00000055; exactly 8 acks, then done.
REQ-028 Dump with out_ready held 0 for 5 cycles at row 3: out_valid and out_data stable, no bus cycle issued, row 4 starts after release.
REQ-029 Responder never acks, TIMEOUT=15: stb high 15 cycles, error pulse, busy=0, done never pulses.
REQ-030 reset during BUS at row 2, then start again: fresh transfer from addr BASE_ADDR, no stale done; start pulsed while busy has no effect.
